// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM arbiter slice.
package sram_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  localparam int PORT_D = 0;
  localparam int PORT_I = 1;
  localparam int PORT_W = 2;

  // Owner of the access on the pins; it follows the access to steer its read data.
  typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I, OWN_W} owner_e;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer flips only when both requesters contend
// in an enabled cycle; requester 0 is preferred out of reset.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (&req_i) begin
        gnt_o[ptr_q] = 1'b1;
        ptr_d        = ~ptr_q;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Owns the async SRAM pins: a reserved display slot every DISP_PERIOD cycles, round-robin I/W
// otherwise. Define SRAM_ARB_PERF_EN to add the perf_d_miss / perf_iw_stall counters.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int AW          = SRAM_AW,
  parameter int DW          = SRAM_DW,
  parameter int DISP_PERIOD = 2
) (
  input  logic          clk50,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [1:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          i_gnt,
  output logic          i_rvalid,
  input  logic          w_req,
  input  logic          w_we,
  input  logic [1:0]    w_be,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_wdata,
  output logic          w_gnt,
  output logic          w_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] SRAM_ADDR,
  inout  wire  [DW-1:0] SRAM_DQ,
  output logic          SRAM_CE_N,
  output logic          SRAM_OE_N,
  output logic          SRAM_WE_N,
  output logic          SRAM_UB_N,
  output logic          SRAM_LB_N
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_d_miss,
  output logic [15:0]   perf_iw_stall
`endif
);

  localparam logic [3:0] SLOT_LAST = 4'(DISP_PERIOD - 1);

  logic [2:0]    req;
  logic [1:0]    iw_gnt;
  logic          disp_win;
  logic [3:0]    slot_q, slot_d;
  owner_e        owner_q, owner_d;
  logic          wr_d;
  logic [1:0]    be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dq_q, dq_d;
  logic          dq_oe_q, dq_oe_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic          d_rvalid_q, d_rvalid_d, i_rvalid_q, i_rvalid_d, w_rvalid_q, w_rvalid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d, rdata_q, rdata_d;

  assign req[PORT_D] = d_req;
  assign req[PORT_I] = i_req;
  assign req[PORT_W] = w_req;

  // A claimed display slot keeps the shared arbiter (and its pointer) frozen.
  assign disp_win = (slot_q == 4'd0) && req[PORT_D];

  rr_arb2 u_rr (
    .clk_i  (clk50),
    .rst_ni (rst_n),
    .en_i   (!disp_win),
    .req_i  ({req[PORT_W], req[PORT_I]}),
    .gnt_o  (iw_gnt)
  );

  always_comb begin
    slot_d  = (slot_q == SLOT_LAST) ? 4'd0 : slot_q + 4'd1;
    owner_d = OWN_NONE;
    addr_d  = addr_q;
    dq_d    = dq_q;
    wr_d    = 1'b0;
    be_d    = 2'b00;
    if (disp_win)       owner_d = OWN_D;
    else if (iw_gnt[0]) owner_d = OWN_I;
    else if (iw_gnt[1]) owner_d = OWN_W;
    case (owner_d)
      OWN_D: begin addr_d = d_addr; be_d = 2'b11; end
      OWN_I: begin addr_d = i_addr; be_d = i_be; wr_d = i_we; dq_d = i_wdata; end
      OWN_W: begin addr_d = w_addr; be_d = w_be; wr_d = w_we; dq_d = w_wdata; end
      default: ;
    endcase
    ce_n_d  = (owner_d == OWN_NONE);
    oe_n_d  = ce_n_d | wr_d;
    we_n_d  = ce_n_d | ~wr_d;
    ub_n_d  = ce_n_d | ~be_d[1];
    lb_n_d  = ce_n_d | ~be_d[0];
    dq_oe_d = ~ce_n_d & wr_d;
  end

  // OE_N low marks a read on the pins this cycle; its data is captured at the closing edge.
  always_comb begin
    d_rvalid_d = 1'b0;
    i_rvalid_d = 1'b0;
    w_rvalid_d = 1'b0;
    d_rdata_d  = d_rdata_q;
    rdata_d    = rdata_q;
    if (!oe_n_q) begin
      case (owner_q)
        OWN_D: begin d_rvalid_d = 1'b1; d_rdata_d = SRAM_DQ; end
        OWN_I: begin i_rvalid_d = 1'b1; rdata_d = SRAM_DQ; end
        OWN_W: begin w_rvalid_d = 1'b1; rdata_d = SRAM_DQ; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      slot_q     <= 4'd0;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      dq_q       <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      d_rvalid_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      w_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      rdata_q    <= '0;
    end else begin
      slot_q     <= slot_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
      d_rvalid_q <= d_rvalid_d;
      i_rvalid_q <= i_rvalid_d;
      w_rvalid_q <= w_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign d_gnt     = (owner_q == OWN_D);
  assign i_gnt     = (owner_q == OWN_I);
  assign w_gnt     = (owner_q == OWN_W);
  assign d_rvalid  = d_rvalid_q;
  assign i_rvalid  = i_rvalid_q;
  assign w_rvalid  = w_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign rdata     = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_DQ   = dq_oe_q ? dq_q : 'z;

`ifdef SRAM_ARB_PERF_EN
  logic [15:0] d_miss_q, iw_stall_q;

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      d_miss_q   <= '0;
      iw_stall_q <= '0;
    end else begin
      if ((slot_q == 4'd0) && d_req && (owner_d != OWN_D) && (d_miss_q != 16'hFFFF))
        d_miss_q <= d_miss_q + 16'd1;
      if (((i_req && !i_gnt) || (w_req && !w_gnt)) && (iw_stall_q != 16'hFFFF))
        iw_stall_q <= iw_stall_q + 16'd1;
    end
  end

  assign perf_d_miss   = d_miss_q;
  assign perf_iw_stall = iw_stall_q;
`endif

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Owns the external 16-bit async SRAM pins and shares them between three requesters: display read (port D), SRAM clear (port I) and line-draw read/write (port W).
- Replaces the free-running odd/even slot toggle in the top level with a guaranteed display slot plus round-robin for I/W.
- Sits between framebuffer, sram_init and draw on one side and the SRAM pins on the other.
- All SRAM pins are registered; one access per clk50 cycle.

Parameters:
- AW, 20, SRAM word-address width.
- DW, 16, SRAM data width.
- DISP_PERIOD, 2, display owns one slot in every DISP_PERIOD cycles (legal range 2..16).

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous reset, active-low.
- d_req  in  1  display read request.
- d_addr  in  AW  display address.
- d_gnt  out  1  display access issued this cycle.
- d_rvalid  out  1  d_rdata valid.
- d_rdata  out  DW  display read data.
- i_req, i_we, i_be[1:0], i_addr[AW], i_wdata[DW]  in  init port; i_we=0 is a read.
- i_gnt  out  1  init access issued.
- i_rvalid  out  1  init read data valid.
- w_req, w_we, w_be[1:0], w_addr[AW], w_wdata[DW]  in  draw port.
- w_gnt  out  1  draw access issued.
- w_rvalid  out  1  draw read data valid.
- rdata  out  DW  shared read data for I and W, qualified by i_rvalid / w_rvalid.
- SRAM_ADDR  out  AW  SRAM address.
- SRAM_DQ  inout  DW  SRAM data.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls.

Behaviour:
- Reset values:
  - All gnt/rvalid outputs 0; rdata and d_rdata 0.
  - SRAM_CE_N, OE_N, WE_N, UB_N, LB_N = 1; SRAM_ADDR = 0; SRAM_DQ hi-Z.
  - slot counter 0; rr pointer = I.
- Slot counter:
  - Counts 0..DISP_PERIOD-1 and wraps.
  - Slot 0 is the display slot; all other slots are shared slots.
- Arbitration, evaluated in cycle T on the sampled req inputs:
  - Display slot: D wins if d_req=1; otherwise the slot falls through to shared arbitration.
  - Shared arbitration: if both I and W request, the rr pointer picks the winner, then the pointer flips to the other port. If only one requests, it wins and the pointer does not change. If neither requests, the cycle is idle.
  - A port requesting outside the display slot never displaces D's reserved slot.
- Handshake:
  - Requester holds req, addr, we, be and wdata stable until it sees gnt.
  - req may deassert only in the cycle after gnt, or stay high for back-to-back accesses.
  - gnt is asserted in cycle T+1, aligned with the registered SRAM access.
- Access cycle (T+1):
  - SRAM_CE_N=0.
  - UB_N/LB_N = ~be; D is always 2'b11.
  - Read: OE_N=0, WE_N=1, DQ hi-Z.
  - Write: OE_N=1, WE_N=0, DQ driven with wdata for that whole cycle only.
  - Idle cycle: CE_N=OE_N=WE_N=1, DQ hi-Z.
- Read latency: DQ is captured at the end of T+1; the rvalid pulse and data appear in cycle T+2, one cycle wide.
  - D reads return on d_rdata only.
  - I and W reads return on rdata; only the matching rvalid is raised.
- Writes produce no rvalid.
- Write followed by read (any ports): the DQ driver is released in the same edge that asserts OE_N, so no dead cycle is inserted.
- Simultaneous D and I/W requests in the display slot: D wins, and the I/W arbitration does not advance the rr pointer.
- Reset mid-operation: the next edge with rst_n=0 forces all reset values, drops any in-flight rvalid, and ignores pending requests.

Optional Feature:
- Macro: SRAM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_d_miss[15:0] and perf_iw_stall[15:0], both saturating counters cleared by reset.
  - perf_d_miss increments on every display slot in which d_req=1 but the display access was not issued. This must stay 0 by construction and is a checkable invariant.
  - perf_iw_stall increments on every cycle where I or W holds req without gnt.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_pkg holds:
  - SRAM_AW / SRAM_DW constants.
  - Port index constants PORT_D/PORT_I/PORT_W.
  - The grant-owner enum {OWN_NONE, OWN_D, OWN_I, OWN_W}, which is registered with each access to route the return data.
- One sub-module, rr_arb2: two-requester round-robin with a pointer, used for the shared slot.
- Pin drive, slot counter and data return stay in sram_arbiter.

Test Plan:
- Display only, DISP_PERIOD=2, d_req held, d_addr=0x00100 -> d_gnt every other cycle; CE_N=0, OE_N=0 in those cycles; d_rvalid one cycle after each gnt, carrying the preloaded word.
- I and W both held, D idle -> grants alternate I, W, I, W starting with I after reset; every cycle is granted, including display slots.
- D, I, W all held -> D granted exactly every 2nd cycle; I/W alternate in the remaining cycles; perf_d_miss=0.
- W write addr=0x12345, wdata=0xBEEF, be=2'b01, then D read of same addr -> WE_N=0, LB_N=0, UB_N=1 during the write; the read returns 0x??EF with the preset upper byte unchanged; DQ is not driven during the read cycle.
- I read addr=0x00002 -> only i_rvalid fires, at T+2, on rdata; w_rvalid and d_rvalid stay 0.
- rst_n=0 on the cycle after a W read grant -> no w_rvalid; all pins return to reset values; rr pointer = I on release.
